// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared pointer/count types for the FIFO status controller
package fifo_pkg;

    localparam int FIFO_ADDR_W = 4;

    typedef logic [FIFO_ADDR_W:0] ptr_t;
    typedef logic [FIFO_ADDR_W:0] cnt_t;

    // Occupancy from wrap-bit pointers; modular subtraction handles the wrap.
    function automatic cnt_t ptr_diff(input ptr_t wp, input ptr_t rp);
        return cnt_t'(wp - rp);
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// rtl/fifo_ptr.sv - wrap-bit pointer register with increment enable
module fifo_ptr #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] ptr,
    output logic [W-1:0] ptr_nxt
);

    assign ptr_nxt = ptr + {{(W-1){1'b0}}, inc};

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_nxt;
        end
    end

endmodule

// File: rtl/fifo_status_ctrl.sv
// rtl/fifo_status_ctrl.sv - push/pop qualification, occupancy, status and sticky error flags
module fifo_status_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_W = FIFO_ADDR_W,
    parameter int AF_RST = 12,
    parameter int AE_RST = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_req,
    input  logic              rd_req,
    input  logic              thr_we,
    input  logic [ADDR_W:0]   af_level,
    input  logic [ADDR_W:0]   ae_level,
    input  logic              clr_err,
    output logic              wr_en,
    output logic              rd_en,
    output logic [ADDR_W-1:0] waddr,
    output logic [ADDR_W-1:0] raddr,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              overflow,
    output logic              underflow
);

    localparam int              DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE_C    = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] AF_RST_C = (AF_RST > DEPTH) ? DEPTH_C : AF_RST[ADDR_W:0];
    localparam logic [ADDR_W:0] AE_RST_C = (AE_RST > DEPTH) ? DEPTH_C : AE_RST[ADDR_W:0];

    logic [ADDR_W:0] wptr, wptr_nxt, rptr, rptr_nxt;
    logic [ADDR_W:0] count_nxt;
    logic [ADDR_W:0] af_thr, ae_thr, af_thr_nxt, ae_thr_nxt;

    function automatic logic [ADDR_W:0] sat_level(input logic [ADDR_W:0] lvl);
        return (lvl > DEPTH_C) ? DEPTH_C : lvl;
    endfunction

    // A push into a full FIFO is still safe when a pop frees the slot the same cycle.
    assign wr_en = wr_req & (~full | rd_req);
    assign rd_en = rd_req & ~empty;
    assign waddr = wptr[ADDR_W-1:0];
    assign raddr = rptr[ADDR_W-1:0];

    fifo_ptr #(.W(ADDR_W + 1)) u_wptr (
        .clk     (clk),
        .reset   (reset),
        .inc     (wr_en),
        .ptr     (wptr),
        .ptr_nxt (wptr_nxt)
    );

    fifo_ptr #(.W(ADDR_W + 1)) u_rptr (
        .clk     (clk),
        .reset   (reset),
        .inc     (rd_en),
        .ptr     (rptr),
        .ptr_nxt (rptr_nxt)
    );

    always_comb begin
        count_nxt = count;
        if (wr_en && !rd_en) begin
            count_nxt = count + ONE_C;
        end else if (rd_en && !wr_en) begin
            count_nxt = count - ONE_C;
        end
        af_thr_nxt = thr_we ? sat_level(af_level) : af_thr;
        ae_thr_nxt = thr_we ? sat_level(ae_level) : ae_thr;
    end

    // Flags come from next-state values so they line up with count.
    always_ff @(posedge clk) begin
        if (reset) begin
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
            af_thr       <= AF_RST_C;
            ae_thr       <= AE_RST_C;
        end else begin
            count        <= count_nxt;
            full         <= (wptr_nxt[ADDR_W] != rptr_nxt[ADDR_W]) &&
                            (wptr_nxt[ADDR_W-1:0] == rptr_nxt[ADDR_W-1:0]);
            empty        <= (wptr_nxt == rptr_nxt);
            almost_full  <= (count_nxt >= af_thr_nxt);
            almost_empty <= (count_nxt <= ae_thr_nxt);
            overflow     <= (wr_req & ~wr_en) | (overflow & ~clr_err);
            underflow    <= (rd_req & ~rd_en) | (underflow & ~clr_err);
            af_thr       <= af_thr_nxt;
            ae_thr       <= ae_thr_nxt;
        end
    end

    a_count_max: assert property (@(posedge clk) disable iff (reset) count <= DEPTH_C);
    a_full_empty: assert property (@(posedge clk) disable iff (reset) !(full && empty));
    a_count_ptr: assert property (@(posedge clk) disable iff (reset)
        count == (wptr - rptr));
    a_count_pkg: assert property (@(posedge clk) disable iff (reset)
        (ADDR_W != FIFO_ADDR_W) || (cnt_t'(count) == ptr_diff(ptr_t'(wptr), ptr_t'(rptr))));

endmodule

// File: tb/tb_fifo_status_ctrl.sv
// tb/tb_fifo_status_ctrl.sv - directed and randomised checks of fifo_status_ctrl
module tb_fifo_status_ctrl;

    logic       clk;
    logic       reset;
    logic       wr_req, rd_req, thr_we, clr_err;
    logic [4:0] af_level, ae_level;
    logic       wr_en, rd_en;
    logic [3:0] waddr, raddr;
    logic [4:0] count;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;

    int errors = 0;
    int checks = 0;

    fifo_status_ctrl #(.ADDR_W(4), .AF_RST(12), .AE_RST(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_req       (wr_req),
        .rd_req       (rd_req),
        .thr_we       (thr_we),
        .af_level     (af_level),
        .ae_level     (ae_level),
        .clr_err      (clr_err),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .waddr        (waddr),
        .raddr        (raddr),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_req = 0; rd_req = 0; thr_we = 0; clr_err = 0;
    endtask

    task automatic test_reset();
        idle(); af_level = 0; ae_level = 0;
        reset = 1; tick(); tick(); reset = 0;
        checks++;
        if ({count, empty, almost_empty, full, almost_full, overflow, underflow} !== {5'd0, 6'b110000}) begin
            errors++;
            $display("FAIL reset_state: count=%0d e=%b ae=%b f=%b af=%b ov=%b un=%b, need 0 1 1 0 0 0 0",
                     count, empty, almost_empty, full, almost_full, overflow, underflow);
        end
        checks++;
        if (waddr !== 4'd0 || raddr !== 4'd0) begin
            errors++; $display("FAIL reset_addr: waddr=%0d raddr=%0d, need 0 0", waddr, raddr);
        end
    endtask

    task automatic test_fill_overflow();
        for (int i = 1; i <= 16; i++) begin
            wr_req = 1; #1;
            checks++;
            if (wr_en !== 1'b1) begin errors++; $display("FAIL fill_wr_en: push %0d wr_en=%b, need 1", i, wr_en); end
            tick();
            checks++;
            if (count !== 5'(i) || full !== (i == 16) || empty !== 1'b0 ||
                almost_full !== (i >= 12) || almost_empty !== (i <= 2)) begin
                errors++;
                $display("FAIL fill_flags: push %0d count=%0d f=%b e=%b af=%b ae=%b", i, count, full, empty, almost_full, almost_empty);
            end
        end
        #1;
        checks++;
        if (wr_en !== 1'b0) begin errors++; $display("FAIL push17_wr_en: wr_en=%b, need 0", wr_en); end
        tick(); wr_req = 0;
        checks++;
        if (overflow !== 1'b1 || count !== 5'd16) begin
            errors++; $display("FAIL push17_overflow: ov=%b count=%0d, need 1 16", overflow, count);
        end
        clr_err = 1; tick(); clr_err = 0;
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL clr_overflow: ov=%b, need 0", overflow); end
    endtask

    task automatic test_full_passthrough();
        for (int i = 0; i < 20; i++) begin
            wr_req = 1; rd_req = 1; #1;
            checks++;
            if (wr_en !== 1'b1 || rd_en !== 1'b1) begin
                errors++; $display("FAIL pass_enables: cycle %0d wr_en=%b rd_en=%b, need 1 1", i, wr_en, rd_en);
            end
            tick();
            checks++;
            if (count !== 5'd16 || full !== 1'b1 || overflow !== 1'b0 ||
                waddr !== 4'((i + 1) % 16) || raddr !== 4'((i + 1) % 16)) begin
                errors++;
                $display("FAIL pass_state: cycle %0d count=%0d f=%b ov=%b waddr=%0d raddr=%0d, need 16 1 0 %0d %0d",
                         i, count, full, overflow, waddr, raddr, (i + 1) % 16, (i + 1) % 16);
            end
        end
        wr_req = 0;
        for (int i = 15; i >= 0; i--) begin
            rd_req = 1; tick();
            checks++;
            if (count !== 5'(i) || empty !== (i == 0) || full !== 1'b0) begin
                errors++; $display("FAIL drain: count=%0d e=%b f=%b, need %0d", count, empty, full, i);
            end
        end
        rd_req = 0;
    endtask

    task automatic test_underflow();
        rd_req = 1; #1;
        checks++;
        if (rd_en !== 1'b0) begin errors++; $display("FAIL empty_rd_en: rd_en=%b, need 0", rd_en); end
        tick();
        checks++;
        if (underflow !== 1'b1 || count !== 5'd0 || empty !== 1'b1) begin
            errors++; $display("FAIL underflow_set: un=%b count=%0d e=%b, need 1 0 1", underflow, count, empty);
        end
        wr_req = 1; #1;
        checks++;
        if (wr_en !== 1'b1 || rd_en !== 1'b0) begin
            errors++; $display("FAIL empty_pushpop_en: wr_en=%b rd_en=%b, need 1 0", wr_en, rd_en);
        end
        tick(); wr_req = 0; rd_req = 0;
        checks++;
        if (count !== 5'd1 || underflow !== 1'b1 || empty !== 1'b0) begin
            errors++; $display("FAIL empty_pushpop: count=%0d un=%b e=%b, need 1 1 0", count, underflow, empty);
        end
        clr_err = 1; tick(); clr_err = 0;
        checks++;
        if (underflow !== 1'b0) begin errors++; $display("FAIL clr_underflow: un=%b, need 0", underflow); end
        rd_req = 1; tick();
        clr_err = 1; tick(); rd_req = 0; clr_err = 0;
        checks++;
        if (underflow !== 1'b1 || count !== 5'd0) begin
            errors++; $display("FAIL set_beats_clr: un=%b count=%0d, need 1 0", underflow, count);
        end
        clr_err = 1; tick(); clr_err = 0;
    endtask

    task automatic test_thresholds();
        wr_req = 1; tick(); tick(); tick(); wr_req = 0;
        af_level = 5'd4; ae_level = 5'd1; thr_we = 1; tick(); thr_we = 0;
        checks++;
        if (count !== 5'd3 || almost_full !== 1'b0 || almost_empty !== 1'b0) begin
            errors++; $display("FAIL thr_load: count=%0d af=%b ae=%b, need 3 0 0", count, almost_full, almost_empty);
        end
        wr_req = 1; tick(); wr_req = 0;
        checks++;
        if (almost_full !== 1'b1) begin errors++; $display("FAIL thr_af4: af=%b, need 1", almost_full); end
        af_level = 5'd31; ae_level = 5'd5; thr_we = 1; tick(); thr_we = 0;
        checks++;
        if (almost_full !== 1'b0 || almost_empty !== 1'b1) begin
            errors++; $display("FAIL thr_sat_load: af=%b ae=%b, need 0 1", almost_full, almost_empty);
        end
        for (int i = 5; i <= 16; i++) begin
            wr_req = 1; tick();
            checks++;
            if (almost_full !== (i == 16) || almost_empty !== (i <= 5)) begin
                errors++; $display("FAIL thr_sat_walk: count=%0d af=%b ae=%b", count, almost_full, almost_empty);
            end
        end
        wr_req = 0;
    endtask

    task automatic test_reset_mid_burst();
        wr_req = 1; tick(); wr_req = 0;
        for (int i = 0; i < 7; i++) begin rd_req = 1; tick(); end
        rd_req = 0;
        checks++;
        if (count !== 5'd9 || overflow !== 1'b1) begin
            errors++; $display("FAIL preburst: count=%0d ov=%b, need 9 1", count, overflow);
        end
        wr_req = 1; rd_req = 1; reset = 1; tick(); reset = 0; wr_req = 0; rd_req = 0;
        checks++;
        if ({count, empty, almost_empty, full, almost_full, overflow, underflow, waddr, raddr} !==
            {5'd0, 6'b110000, 8'd0}) begin
            errors++;
            $display("FAIL midburst_reset: count=%0d e=%b ae=%b f=%b af=%b ov=%b un=%b wa=%0d ra=%0d",
                     count, empty, almost_empty, full, almost_full, overflow, underflow, waddr, raddr);
        end
        for (int i = 1; i <= 12; i++) begin
            wr_req = 1; tick();
            checks++;
            if (almost_full !== (i >= 12) || almost_empty !== (i <= 2)) begin
                errors++; $display("FAIL rst_thresholds: count=%0d af=%b ae=%b", count, almost_full, almost_empty);
            end
        end
        wr_req = 0;
    endtask

    task automatic test_random();
        int m_cnt = 12;
        int m_w = 12;
        int m_r = 0;
        logic m_ov = 0, m_un = 0, m_we, m_re;
        int bias;
        for (int c = 0; c < 10000; c++) begin
            bias = ((c / 500) % 2 == 0) ? 70 : 30;
            wr_req  = ($urandom_range(99) < bias);
            rd_req  = ($urandom_range(99) < 100 - bias);
            clr_err = ($urandom_range(99) < 3);
            m_we = wr_req & ((m_cnt != 16) | rd_req);
            m_re = rd_req & (m_cnt != 0);
            #1;
            checks++;
            if (wr_en !== m_we || rd_en !== m_re) begin
                errors++; $display("FAIL rnd_en: cycle %0d wr_en=%b rd_en=%b, need %b %b", c, wr_en, rd_en, m_we, m_re);
            end
            m_ov = (wr_req & ~m_we) | (m_ov & ~clr_err);
            m_un = (rd_req & ~m_re) | (m_un & ~clr_err);
            m_cnt = m_cnt + int'(m_we) - int'(m_re);
            m_w = (m_w + int'(m_we)) % 32;
            m_r = (m_r + int'(m_re)) % 32;
            tick();
            checks++;
            if (count !== 5'(m_cnt) || full !== (m_cnt == 16) || empty !== (m_cnt == 0) ||
                almost_full !== (m_cnt >= 12) || almost_empty !== (m_cnt <= 2) ||
                overflow !== m_ov || underflow !== m_un ||
                waddr !== 4'(m_w % 16) || raddr !== 4'(m_r % 16)) begin
                errors++;
                $display("FAIL rnd_state: cycle %0d count=%0d need %0d f=%b e=%b af=%b ae=%b ov=%b/%b un=%b/%b wa=%0d ra=%0d",
                         c, count, m_cnt, full, empty, almost_full, almost_empty, overflow, m_ov, underflow, m_un, waddr, raddr);
            end
        end
        idle();
    endtask

    initial begin
        reset = 1;
        idle();
        af_level = 0;
        ae_level = 0;
        test_reset();
        test_fill_overflow();
        test_full_passthrough();
        test_underflow();
        test_thresholds();
        test_reset_mid_burst();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
